h14tx_pattern_gen: RTL and testbench

- Parametrised, mode-selectable test-pattern source for the h14tx video path.
- Replaces the fixed two-colour switch mux in front of h14tx_dvo.
- Consumes the DVO pixel coordinates (x, y) and returns a registered RGB pixel.
- The on-board switch is synchronised and debounced, and each press cycles the pattern mode. A new mode takes effect only at a frame boundary.

---
 rtl/h14tx_pattern_gen.sv | 171 +++++++++++++++++
 tb/tb_h14tx_pattern_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_pattern_gen.sv
// Mode-selectable test-pattern source for the h14tx video path.
// Takes DVO pixel coordinates and returns a registered RGB pixel; a debounced button cycles the mode.
module h14tx_pattern_gen #(
  parameter int BitWidth       = 12,
  parameter int BitHeight      = 11,
  parameter int ActiveWidth    = 1280,
  parameter int ActiveHeight   = 720,
  parameter int DebounceCycles = 1000000,
  parameter int CheckerLog2    = 5,
  parameter int LineStep       = 4,
  parameter int DefaultMode    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic                 switch,
  output logic [2:0][7:0]      video,
  output logic [2:0]           mode,
  output logic                 frame_tick
);

  typedef logic [2:0][7:0] rgb_t;

  localparam int   BarWidth = ActiveWidth / 8;
  localparam int   DebW     = $clog2(DebounceCycles);
  localparam int   SumW     = BitWidth + 1;
  localparam logic [2:0]      ModeReset = 3'(DefaultMode);
  localparam logic [DebW-1:0] DebLast   = DebW'(DebounceCycles - 1);
  localparam logic [BitWidth-1:0] BarLast = BitWidth'(BarWidth - 1);
  localparam rgb_t White = 24'hFFFFFF;
  localparam rgb_t Grey  = 24'h111111;

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    return (m >= 3'd5) ? 3'd0 : m + 3'd1;
  endfunction

  function automatic logic [BitWidth-1:0] advance_line(input logic [BitWidth-1:0] pos);
    logic [SumW-1:0] sum;
    sum = {1'b0, pos} + SumW'(LineStep);
    if (sum >= SumW'(ActiveWidth)) sum = sum - SumW'(ActiveWidth);
    return sum[BitWidth-1:0];
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] idx);
    return (idx == 3'd7) ? 3'd7 : idx + 3'd1;
  endfunction

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic                 sync_0, sync_1;
  logic                 deb_level;
  logic [DebW-1:0]      deb_cnt;
  logic                 press;
  logic [2:0]           pending;
  logic                 at_origin, prev_origin, frame_start;
  logic [15:0]          frame_cnt;
  logic [BitWidth-1:0]  line_pos;
  logic [2:0]           bar_idx, bar_idx_cur;
  logic [BitWidth-1:0]  bar_cnt, bar_cnt_cur;
  logic                 active;
  rgb_t                 pix;

  // Switch synchroniser and debouncer
  assign press = (sync_1 != deb_level) && (deb_cnt == DebLast) && sync_1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      pending   <= ModeReset;
    end else begin
      sync_0 <= switch;
      sync_1 <= sync_0;
      if (sync_1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DebLast) begin
        deb_level <= sync_1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (press) pending <= next_mode(pending);
    end
  end

  // Frame boundary: mode switch, frame count and moving-line advance.
  // prev_origin resets high so a release while parked at (0,0) is not a frame start.
  assign at_origin   = (x == '0) && (y == '0);
  assign frame_start = at_origin && !prev_origin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_origin <= 1'b1;
      frame_tick  <= 1'b0;
      mode        <= ModeReset;
      frame_cnt   <= '0;
      line_pos    <= '0;
    end else begin
      prev_origin <= at_origin;
      frame_tick  <= frame_start;
      if (frame_start) begin
        mode      <= pending;
        frame_cnt <= frame_cnt + 16'd1;
        line_pos  <= advance_line(line_pos);
      end
    end
  end

  // Bar tracking: the _cur values describe the pixel currently on x
  always_comb begin
    bar_idx_cur = bar_idx;
    bar_cnt_cur = bar_cnt + 1'b1;
    if (x == '0) begin
      bar_idx_cur = '0;
      bar_cnt_cur = '0;
    end else if (bar_cnt == BarLast) begin
      bar_idx_cur = sat_inc(bar_idx);
      bar_cnt_cur = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else begin
      bar_idx <= bar_idx_cur;
      bar_cnt <= bar_cnt_cur;
    end
  end

  // Pixel generation and output register
  assign active = (x < BitWidth'(ActiveWidth)) && (y < BitHeight'(ActiveHeight));

  always_comb begin
    pix = '0;
    case (mode)
      3'd0: pix = White;
      3'd1: pix = bar_colour(bar_idx_cur);
      3'd2: pix = (x[CheckerLog2] ^ y[CheckerLog2]) ? White : '0;
      3'd3: pix = {3{x[7:0]}};
      3'd4: pix = (x == line_pos) ? White : Grey;
      default: pix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video <= '0;
    end else begin
      video <= active ? pix : '0;
    end
  end

endmodule

// File: tb/tb_h14tx_pattern_gen.sv
// Scoreboard bench for h14tx_pattern_gen: a behavioural model pushes expected pixel/mode/tick
// per driven coordinate, compared one clock later.
module tb_h14tx_pattern_gen;

  localparam int AW = 1280;
  localparam int AH = 720;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [11:0]     x;
  logic [10:0]     y;
  logic            switch;
  logic [2:0][7:0] video;
  logic [2:0]      mode;
  logic            frame_tick;

  always #5 clk = ~clk;

  h14tx_pattern_gen #(
    .BitWidth(12), .BitHeight(11), .ActiveWidth(AW), .ActiveHeight(AH),
    .DebounceCycles(16), .CheckerLog2(5), .LineStep(4), .DefaultMode(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .switch(switch),
    .video(video), .mode(mode), .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [23:0] vid;
    logic [2:0]  md;
    logic        tick;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int m_mode, m_pending, m_linepos;
  bit m_prevzero;

  function automatic logic [23:0] exp_pix(input int xv, input int yv, input int md, input int lp);
    logic [23:0] p;
    int lvl;
    if (xv >= AW || yv >= AH) return 24'h0;
    case (md)
      0: p = 24'hFFFFFF;
      1: begin
        case (xv / (AW / 8))
          0: p = 24'hFFFFFF;
          1: p = 24'hFFFF00;
          2: p = 24'h00FFFF;
          3: p = 24'h00FF00;
          4: p = 24'hFF00FF;
          5: p = 24'hFF0000;
          6: p = 24'h0000FF;
          default: p = 24'h000000;
        endcase
      end
      2: p = ((((xv >> 5) ^ (yv >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
      3: begin
        lvl = xv & 255;
        p = {lvl[7:0], lvl[7:0], lvl[7:0]};
      end
      4: p = (xv == lp) ? 24'hFFFFFF : 24'h111111;
      default: p = 24'h0;
    endcase
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 1; m_pending = 1; m_linepos = 0; m_prevzero = 1'b1;
    sb.delete();
  endtask

  task automatic step(input int xv, input int yv);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (video !== e.vid || mode !== e.md || frame_tick !== e.tick) begin
        failures++;
        $display("FAIL pixel video=%h mode=%0d tick=%b expected video=%h mode=%0d tick=%b (at x=%0d y=%0d)",
                 video, mode, frame_tick, e.vid, e.md, e.tick, x, y);
      end
    end
    x = xv[11:0];
    y = yv[10:0];
    e.vid  = exp_pix(xv, yv, m_mode, m_linepos);
    e.tick = 1'b0;
    if (xv == 0 && yv == 0 && !m_prevzero) begin
      e.tick = 1'b1;
      m_mode = m_pending;
      m_linepos += 4;
      if (m_linepos >= AW) m_linepos -= AW;
    end
    m_prevzero = (xv == 0 && yv == 0);
    e.md = m_mode[2:0];
    sb.push_back(e);
  endtask

  task automatic frame_start_seq();
    step(1400, 5);
    step(0, 0);
    step(1, 0);
  endtask

  task automatic press_switch(input int bounces);
    for (int b = 0; b < bounces; b++) begin
      switch = 1'b1; repeat (5) step(1500, 800);
      switch = 1'b0; repeat (5) step(1500, 800);
    end
    switch = 1'b1; repeat (40) step(1500, 800);
    switch = 1'b0; repeat (40) step(1500, 800);
    m_pending = (m_pending == 5) ? 0 : m_pending + 1;
  endtask

  task automatic sweep_line(input int yv, input int last);
    for (int i = 0; i <= last; i++) step(i, yv);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0; switch = 1'b0; x = '0; y = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (video !== 24'h0) begin failures++; $display("FAIL reset_video got=%h want=000000", video); end
    checks++;
    if (mode !== 3'd1) begin failures++; $display("FAIL reset_mode got=%0d want=1", mode); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (video !== 24'h0) begin failures++; $display("FAIL release_video got=%h want=000000", video); end
    sweep_line(0, 1285);
  endtask

  task automatic test_debounce();
    press_switch(3);
    repeat (3) step(1500, 800);
    frame_start_seq();
    for (int i = 2; i < 12; i++) step(i, 0);
  endtask

  task automatic test_checker();
    int px[10] = '{31, 32, 32, 31, 63, 64, 100, 1279, 1280, 5};
    int py[10] = '{0, 0, 32, 32, 33, 64, 700, 719, 5, 720};
    for (int i = 0; i < 10; i++) step(px[i], py[i]);
  endtask

  task automatic test_reset_midframe();
    repeat (3) step(500, 300);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (video !== 24'h0) begin failures++; $display("FAIL midreset_video got=%h want=000000", video); end
    checks++;
    if (mode !== 3'd1) begin failures++; $display("FAIL midreset_mode got=%0d want=1", mode); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL midreset_tick got=%b want=0", frame_tick); end
    x = 12'd1300; y = 11'd300;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1300 + i, 300);
    step(0, 0);
    step(1, 0);
    step(1400, 5);
  endtask

  task automatic test_moving();
    int guard;
    repeat (3) press_switch(1);
    frame_start_seq();
    sweep_line(1, 1283);
    frame_start_seq();
    sweep_line(1, 1283);
    frame_start_seq();
    sweep_line(1, 1283);
    guard = 0;
    while (m_linepos != 1276 && guard < 400) begin
      frame_start_seq();
      guard++;
    end
    frame_start_seq();
    sweep_line(2, 1283);
  endtask

  task automatic test_wrap();
    exp_t e;
    press_switch(1);
    frame_start_seq();
    for (int i = 10; i < 20; i++) step(i, 3);
    press_switch(1);
    frame_start_seq();
    for (int i = 10; i < 20; i++) step(i, 3);
    press_switch(1);
    press_switch(1);
    frame_start_seq();
    for (int i = 28; i < 36; i++) step(i, 40);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (video !== e.vid || mode !== e.md || frame_tick !== e.tick) begin
        failures++;
        $display("FAIL drain video=%h mode=%0d tick=%b expected video=%h mode=%0d tick=%b",
                 video, mode, frame_tick, e.vid, e.md, e.tick);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_debounce();
    test_checker();
    test_reset_midframe();
    test_moving();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
